seq_restoring_divider_16by8: RTL and testbench



---
 rtl/seq_restoring_divider_16by8_pkg.sv | 22 ++
 rtl/seq_restoring_divider_16by8_div_restore_step.sv | 33 +++
 rtl/seq_restoring_divider_16by8.sv | 122 ++++++++++++
 tb/tb_seq_restoring_divider_16by8.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_restoring_divider_16by8_pkg.sv
//------------------------------------------------------------------------------
// Module   : seq_restoring_divider_16by8_pkg
// Brief    : Widths, FSM encodings and saturation constant shared by the
//            16-by-8 restoring divider.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package seq_restoring_divider_16by8_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [DIVISOR_W-1:0] QUOT_SAT = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/seq_restoring_divider_16by8_div_restore_step.sv
//------------------------------------------------------------------------------
// Module   : div_restore_step
// Brief    : One restoring-division iteration: trial-subtract the divisor from
//            {R, next bit} and keep the difference unless it borrows.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_restore_step
  import seq_restoring_divider_16by8_pkg::*;
(
  input  logic [DIVISOR_W-1:0] part_rem,
  input  logic                 next_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] part_rem_next,
  output logic                 quot_bit
);

  logic [DIVISOR_W:0]   w_trial;
  logic [DIVISOR_W+1:0] w_diff;
  logic                 w_unused_bits;

  assign w_trial = {part_rem, next_bit};
  assign w_diff  = {1'b0, w_trial} - {2'b00, divisor};

  // R < divisor keeps both dropped MSBs at 0 whenever their value matters.
  assign quot_bit      = ~w_diff[DIVISOR_W+1];
  assign part_rem_next = quot_bit ? w_diff[DIVISOR_W-1:0] : w_trial[DIVISOR_W-1:0];
  assign w_unused_bits = ^{w_diff[DIVISOR_W], w_trial[DIVISOR_W]};

endmodule

`default_nettype wire

// File: rtl/seq_restoring_divider_16by8.sv
//------------------------------------------------------------------------------
// Module   : seq_restoring_divider_16by8
// Brief    : Iterative 16/8 unsigned restoring divider, one quotient bit per
//            clock, valid/ready on both sides, optional skipped LSB iterations.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_restoring_divider_16by8
  import seq_restoring_divider_16by8_pkg::*;
#(
  parameter int SKIP_LSB = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVISOR_W-1:0]  quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_zero,
  output logic                  overflow
);

  localparam int         C_ITER = DIVISOR_W - SKIP_LSB;
  localparam logic [3:0] C_LAST = 4'(C_ITER - 1);

  logic [1:0]           r_state;
  logic [3:0]           r_count;
  logic [DIVISOR_W-1:0] r_part;
  logic [DIVISOR_W-1:0] r_shift;
  logic [DIVISOR_W-1:0] r_divisor;
  logic [DIVISOR_W-1:0] r_quotient;
  logic [DIVISOR_W-1:0] r_remainder;
  logic                 r_div_zero;
  logic                 r_overflow;

  logic [DIVISOR_W-1:0] w_part_next;
  logic [DIVISOR_W-1:0] w_shift_next;
  logic                 w_qbit;

  div_restore_step u_step (
    .part_rem      (r_part),
    .next_bit      (r_shift[DIVISOR_W-1]),
    .divisor       (r_divisor),
    .part_rem_next (w_part_next),
    .quot_bit      (w_qbit)
  );

  assign w_shift_next = {r_shift[DIVISOR_W-2:0], w_qbit};

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;
  assign overflow  = r_overflow;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_part      <= '0;
      r_shift     <= '0;
      r_divisor   <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_divisor <= divisor;
            r_part    <= dividend[DIVIDEND_W-1:DIVISOR_W];
            r_shift   <= dividend[DIVISOR_W-1:0];
            r_count   <= '0;
            if (divisor == '0) begin
              r_state     <= DONE;
              r_div_zero  <= 1'b1;
              r_quotient  <= QUOT_SAT;
              r_remainder <= dividend[DIVISOR_W-1:0];
            end else if (dividend[DIVIDEND_W-1:DIVISOR_W] >= divisor) begin
              r_state     <= DONE;
              r_overflow  <= 1'b1;
              r_quotient  <= QUOT_SAT;
              r_remainder <= dividend[DIVISOR_W-1:0];
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_part  <= w_part_next;
          r_shift <= w_shift_next;
          r_count <= r_count + 4'd1;
          if (r_count == C_LAST) begin
            r_state     <= DONE;
            r_count     <= '0;
            // After C_ITER shifts the quotient bits sit in the low C_ITER bits.
            r_quotient  <= w_shift_next << SKIP_LSB;
            r_remainder <= (SKIP_LSB == 0) ? w_part_next : '0;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state    <= IDLE;
            r_div_zero <= 1'b0;
            r_overflow <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_divider_16by8.sv
//------------------------------------------------------------------------------
// Module   : tb_seq_restoring_divider_16by8
// Brief    : Directed vector table plus back-pressure and mid-run reset
//            sequences for exact (SKIP_LSB=0) and approximate (SKIP_LSB=2) builds.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_restoring_divider_16by8;

  typedef struct {
    int          sel;
    logic [15:0] dd;
    logic [7:0]  dv;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        in_valid0 = 1'b0, in_valid2 = 1'b0;
  logic [15:0] dividend0 = '0,   dividend2 = '0;
  logic [7:0]  divisor0  = '0,   divisor2  = '0;
  logic        out_ready0 = 1'b0, out_ready2 = 1'b0;
  logic        in_ready0, in_ready2, out_valid0, out_valid2;
  logic [7:0]  quotient0, quotient2, remainder0, remainder2;
  logic        div_zero0, div_zero2, overflow0, overflow2;

  int cur_sel = 0;
  int n_cmp   = 0;
  int n_err   = 0;

  logic       m_in_ready, m_out_valid, m_dz, m_ov;
  logic [7:0] m_q, m_r;

  assign m_in_ready  = (cur_sel == 2) ? in_ready2  : in_ready0;
  assign m_out_valid = (cur_sel == 2) ? out_valid2 : out_valid0;
  assign m_q         = (cur_sel == 2) ? quotient2  : quotient0;
  assign m_r         = (cur_sel == 2) ? remainder2 : remainder0;
  assign m_dz        = (cur_sel == 2) ? div_zero2  : div_zero0;
  assign m_ov        = (cur_sel == 2) ? overflow2  : overflow0;

  always #5 clk = ~clk;

  seq_restoring_divider_16by8 #(.SKIP_LSB(0)) u_dut0 (
    .CLK(clk), .RST(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .dividend(dividend0), .divisor(divisor0), .out_valid(out_valid0),
    .out_ready(out_ready0), .quotient(quotient0), .remainder(remainder0),
    .div_zero(div_zero0), .overflow(overflow0)
  );

  seq_restoring_divider_16by8 #(.SKIP_LSB(2)) u_dut2 (
    .CLK(clk), .RST(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .dividend(dividend2), .divisor(divisor2), .out_valid(out_valid2),
    .out_ready(out_ready2), .quotient(quotient2), .remainder(remainder2),
    .div_zero(div_zero2), .overflow(overflow2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [15:0] dd, input logic [7:0] dv);
    if (cur_sel == 2) begin
      in_valid2 = v; dividend2 = dd; divisor2 = dv;
    end else begin
      in_valid0 = v; dividend0 = dd; divisor0 = dv;
    end
  endtask

  task automatic set_out_ready(input logic v);
    if (cur_sel == 2) out_ready2 = v;
    else              out_ready0 = v;
  endtask

  // Issue one op, measure latency (1 = visible right after the accept edge),
  // capture the result, consume it and check the return to IDLE.
  task automatic do_op(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic dz, output logic ov, output int lat);
    @(negedge clk);
    check({tag, " pre in_ready"}, 32'(m_in_ready), 32'd1);
    set_in(1'b1, dd, dv);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 16'h0, 8'h0);
    lat = 1;
    while (!m_out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q = m_q; r = m_r; dz = m_dz; ov = m_ov;
    set_out_ready(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_out_ready(1'b0);
    check({tag, " post out_valid"}, 32'(m_out_valid), 32'd0);
    check({tag, " post in_ready"}, 32'(m_in_ready), 32'd1);
    check({tag, " post div_zero"}, 32'(m_dz), 32'd0);
    check({tag, " post overflow"}, 32'(m_ov), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[12];
    logic [7:0] q, r;
    logic       dz, ov;
    int         lat;
    int         seen;
    string      tag;

    vecs[0]  = '{0, 16'd1000, 8'd7,   8'd142, 8'd6,   1'b0, 1'b0, 9};
    vecs[1]  = '{0, 16'hFE01, 8'hFF,  8'hFF,  8'h00,  1'b0, 1'b0, 9};
    vecs[2]  = '{0, 16'hFF00, 8'hFF,  8'hFF,  8'h00,  1'b0, 1'b1, 1};
    vecs[3]  = '{0, 16'h1234, 8'h00,  8'hFF,  8'h34,  1'b1, 1'b0, 1};
    vecs[4]  = '{0, 16'd255,  8'd16,  8'd15,  8'd15,  1'b0, 1'b0, 9};
    vecs[5]  = '{0, 16'h7FFF, 8'h80,  8'hFF,  8'h7F,  1'b0, 1'b0, 9};
    vecs[6]  = '{0, 16'h0000, 8'h01,  8'h00,  8'h00,  1'b0, 1'b0, 9};
    vecs[7]  = '{0, 16'h0100, 8'h01,  8'hFF,  8'h00,  1'b0, 1'b1, 1};
    vecs[8]  = '{0, 16'd100,  8'd10,  8'd10,  8'd0,   1'b0, 1'b0, 9};
    vecs[9]  = '{2, 16'd1000, 8'd7,   8'd140, 8'd0,   1'b0, 1'b0, 7};
    vecs[10] = '{2, 16'd255,  8'd16,  8'd12,  8'd0,   1'b0, 1'b0, 7};
    vecs[11] = '{2, 16'h0005, 8'h00,  8'hFF,  8'h05,  1'b1, 1'b0, 1};

    // Reset state of both builds
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s <= 2; s += 2) begin
      cur_sel = s;
      #1;
      tag = $sformatf("reset[%0d]", s);
      check({tag, " in_ready"},  32'(m_in_ready),  32'd1);
      check({tag, " out_valid"}, 32'(m_out_valid), 32'd0);
      check({tag, " quotient"},  32'(m_q),         32'd0);
      check({tag, " remainder"}, 32'(m_r),         32'd0);
      check({tag, " div_zero"},  32'(m_dz),        32'd0);
      check({tag, " overflow"},  32'(m_ov),        32'd0);
    end

    for (int i = 0; i < 12; i++) begin
      cur_sel = vecs[i].sel;
      tag = $sformatf("vec%0d", i);
      do_op(tag, vecs[i].dd, vecs[i].dv, q, r, dz, ov, lat);
      check({tag, " quotient"},  32'(q),   32'(vecs[i].q));
      check({tag, " remainder"}, 32'(r),   32'(vecs[i].r));
      check({tag, " div_zero"},  32'(dz),  32'(vecs[i].dz));
      check({tag, " overflow"},  32'(ov),  32'(vecs[i].ov));
      check({tag, " latency"},   32'(lat), 32'(vecs[i].lat));
    end

    // Back-pressure: result held, stray in_valid ignored while DONE
    cur_sel = 0;
    @(negedge clk);
    set_in(1'b1, 16'd1000, 8'd7);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 16'h0, 8'h0);
    lat = 1;
    while (!m_out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp latency", 32'(lat), 32'd9);
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, 16'h0010, 8'h01);
      tag = $sformatf("bp hold%0d", k);
      check({tag, " out_valid"}, 32'(m_out_valid), 32'd1);
      check({tag, " in_ready"},  32'(m_in_ready),  32'd0);
      check({tag, " quotient"},  32'(m_q),         32'd142);
      check({tag, " remainder"}, 32'(m_r),         32'd6);
      @(negedge clk);
    end
    set_in(1'b0, 16'h0, 8'h0);
    set_out_ready(1'b1);
    @(posedge clk);
    @(negedge clk);
    set_out_ready(1'b0);
    check("bp consumed out_valid", 32'(m_out_valid), 32'd0);
    check("bp consumed in_ready",  32'(m_in_ready),  32'd1);
    check("bp kept quotient",      32'(m_q),         32'd142);
    check("bp kept remainder",     32'(m_r),         32'd6);

    // Reset sampled at the 4th RUN edge discards the operation
    set_in(1'b1, 16'd1000, 8'd7);
    @(posedge clk);
    @(negedge clk);
    set_in(1'b0, 16'h0, 8'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst in_ready",  32'(m_in_ready),  32'd1);
    check("midrst out_valid", 32'(m_out_valid), 32'd0);
    check("midrst quotient",  32'(m_q),         32'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (m_out_valid) seen++;
    end
    check("midrst no out_valid", 32'(seen), 32'd0);
    do_op("after rst", 16'd255, 8'd16, q, r, dz, ov, lat);
    check("after rst quotient",  32'(q),   32'd15);
    check("after rst remainder", 32'(r),   32'd15);
    check("after rst latency",   32'(lat), 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
